alu_ctrl: RTL

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - register-file sequencer driving an external combinational ALU
//
// Purpose: accepts 16-bit instructions {opcode, rd, ra, rb}, reads two operands
// from a 16 x WIDTH register file, presents them to an external ALU, captures
// the ALU result and writes it back. Fixed IDLE -> EXEC -> WB sequence, one
// instruction per three cycles, done/err pulses two cycles after the handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid/_ready    instruction handshake (ready only in IDLE)
//   instr[15:0]           [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb
//   alu_op/alu_a/alu_b    registered operation and operands to the ALU
//   alu_y                 combinational ALU result
//   done / err            one-cycle retire pulses (written / illegal)
//   dbg_addr / dbg_data   combinational register file debug read
//
// Configuration macro: ALU_CTRL_LOADI_EN
//   defined   -> opcode 4'hF loads rf[rd] = zero-extended {ra, rb}
//   undefined -> opcode 4'hF is illegal like any opcode above 4'h7

module alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic             done,
    output logic             err,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rf_q [16];
    logic [3:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       rd_q, rd_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             wr_en;
    logic             legal;
`ifdef ALU_CTRL_LOADI_EN
    logic [7:0]       imm_q, imm_d;
`endif

    // rf_q[0] is only ever reset and never written, so it always reads 0.
    assign dbg_data    = rf_q[dbg_addr];
    assign instr_ready = (state_q == IDLE);
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign done        = done_q;
    assign err         = err_q;

`ifdef ALU_CTRL_LOADI_EN
    assign legal = ~alu_op_q[3] | (alu_op_q == 4'hF);
`else
    assign legal = ~alu_op_q[3];
`endif

    always_comb begin
        state_d  = state_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        rd_d     = rd_q;
        res_d    = res_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
`ifdef ALU_CTRL_LOADI_EN
        imm_d    = imm_q;
`endif
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    state_d  = EXEC;
                    alu_op_d = instr[15:12];
                    rd_d     = instr[11:8];
                    // Previous writeback landed on the edge entering IDLE, so
                    // these reads already see it.
                    alu_a_d  = rf_q[instr[7:4]];
                    alu_b_d  = rf_q[instr[3:0]];
`ifdef ALU_CTRL_LOADI_EN
                    imm_d    = instr[7:0];
`endif
                end
            end
            EXEC: begin
                state_d = WB;
`ifdef ALU_CTRL_LOADI_EN
                if (alu_op_q == 4'hF)
                    res_d = {{(WIDTH-8){1'b0}}, imm_q};
                else
                    res_d = alu_y;
`else
                res_d = alu_y;
`endif
            end
            WB: begin
                state_d = IDLE;
                // Pulses are registered so they appear with the write, two
                // edges after the handshake edge.
                if (legal) begin
                    wr_en  = 1'b1;
                    done_d = 1'b1;
                end else begin
                    err_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            rd_q     <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_CTRL_LOADI_EN
            imm_q    <= '0;
`endif
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            rd_q     <= rd_d;
            res_q    <= res_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef ALU_CTRL_LOADI_EN
            imm_q    <= imm_d;
`endif
            if (wr_en && (rd_q != 4'd0)) rf_q[rd_q] <= res_q;
        end
    end

endmodule
